// File: rtl/testbasic14_source.sv
// Single-slot source stage: captures a signed sample, wraps it with a
// sign flag and an alternating read/write mode, and offers it downstream.
package testbasic14_types;
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e              mode;
    logic signed [31:0] x;
    logic               y;
  } CompoundType;
endpackage

module testbasic14_source
  import testbasic14_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] val_in,
  input  logic               val_in_sync,
  output logic               val_in_notify,
  output CompoundType        c_out,
  input  logic               c_out_sync,
  output logic               c_out_notify,
  output logic [15:0]        tx_count
);

  typedef enum logic {
    SECTION_FETCH = 1'b0,
    SECTION_SEND  = 1'b1
  } section_e;

  section_e    section_reg, section_next;
  CompoundType c_out_reg, c_out_next;
  mode_e       mode_reg, mode_next;
  logic        val_in_notify_reg, val_in_notify_next;
  logic        c_out_notify_reg, c_out_notify_next;
  logic [15:0] tx_count_reg, tx_count_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      section_reg       <= SECTION_FETCH;
      c_out_reg         <= '{mode: READ, x: 32'sd0, y: 1'b0};
      mode_reg          <= READ;
      val_in_notify_reg <= 1'b1;
      c_out_notify_reg  <= 1'b0;
      tx_count_reg      <= 16'h0000;
    end else begin
      section_reg       <= section_next;
      c_out_reg         <= c_out_next;
      mode_reg          <= mode_next;
      val_in_notify_reg <= val_in_notify_next;
      c_out_notify_reg  <= c_out_notify_next;
      tx_count_reg      <= tx_count_next;
    end
  end

  // Every output comes straight from a register, so inputs only act at the edge.
  always_comb begin
    section_next       = section_reg;
    c_out_next         = c_out_reg;
    mode_next          = mode_reg;
    val_in_notify_next = val_in_notify_reg;
    c_out_notify_next  = c_out_notify_reg;
    tx_count_next      = tx_count_reg;
    case (section_reg)
      SECTION_FETCH: begin
        if (val_in_sync) begin
          c_out_next.x       = val_in;
          c_out_next.y       = val_in[31];
          c_out_next.mode    = mode_reg;
          val_in_notify_next = 1'b0;
          c_out_notify_next  = 1'b1;
          section_next       = SECTION_SEND;
        end
      end
      SECTION_SEND: begin
        // val_in_sync is deliberately not looked at here.
        if (c_out_sync) begin
          c_out_notify_next  = 1'b0;
          val_in_notify_next = 1'b1;
          mode_next          = (mode_reg == READ) ? WRITE : READ;
          tx_count_next      = tx_count_reg + 16'd1;
          section_next       = SECTION_FETCH;
        end
      end
      default: section_next = SECTION_FETCH;
    endcase
  end

  assign val_in_notify = val_in_notify_reg;
  assign c_out_notify  = c_out_notify_reg;
  assign c_out         = c_out_reg;
  assign tx_count      = tx_count_reg;

endmodule

// File: tb/tb_testbasic14_source.sv
// Directed bench for testbasic14_source: hand-computed expectations for
// capture, alternation, backpressure, sign flag, counter wrap and async reset.
module tb_testbasic14_source;
  import testbasic14_types::*;

  logic               clk;
  logic               rst;
  logic signed [31:0] val_in;
  logic               val_in_sync;
  logic               val_in_notify;
  CompoundType        c_out;
  logic               c_out_sync;
  logic               c_out_notify;
  logic [15:0]        tx_count;

  int checks;
  int failures;

  testbasic14_source dut (
    .clk           (clk),
    .rst           (rst),
    .val_in        (val_in),
    .val_in_sync   (val_in_sync),
    .val_in_notify (val_in_notify),
    .c_out         (c_out),
    .c_out_sync    (c_out_sync),
    .c_out_notify  (c_out_notify),
    .tx_count      (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic CompoundType mk(input mode_e m, input logic signed [31:0] x, input logic y);
    CompoundType c;
    c.mode = m;
    c.x    = x;
    c.y    = y;
    return c;
  endfunction

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    val_in_sync = 1'b0;
    c_out_sync = 1'b0;
    val_in = 32'sd0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Capture one sample with the consumer ready, check it, then complete the transfer.
  task automatic pass_sample(input string tag, input logic signed [31:0] v, input CompoundType exp_c,
                             input logic [15:0] exp_tx);
    val_in = v;
    val_in_sync = 1'b1;
    c_out_sync = 1'b1;
    tick();
    val_in_sync = 1'b0;
    check_val({tag, "_c_out"}, 64'(c_out), 64'(exp_c));
    check_val({tag, "_notify"}, {62'd0, val_in_notify, c_out_notify}, 64'b01);
    tick();
    check_val({tag, "_tx"}, 64'(tx_count), 64'(exp_tx));
    check_val({tag, "_idle"}, {62'd0, val_in_notify, c_out_notify}, 64'b10);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    val_in_sync = 1'b0;
    c_out_sync = 1'b0;
    val_in = 32'sd0;
    #2;
    rst = 1'b0;
    #1;
    check_val("reset_c_out", 64'(c_out), 64'(mk(READ, 32'sd0, 1'b0)));
    check_val("reset_notify", {62'd0, val_in_notify, c_out_notify}, 64'b10);
    check_val("reset_tx", 64'(tx_count), 64'd0);

    // First sample after reset.
    do_reset();
    pass_sample("s1", 32'sd5, mk(READ, 32'sd5, 1'b0), 16'd1);

    // Back-to-back samples alternate mode.
    do_reset();
    pass_sample("bb7", 32'sd7, mk(READ, 32'sd7, 1'b0), 16'd1);
    pass_sample("bbm3", -32'sd3, mk(WRITE, -32'sd3, 1'b1), 16'd2);
    pass_sample("bb0", 32'sd0, mk(READ, 32'sd0, 1'b0), 16'd3);

    // Backpressure with ignored input pulses.
    do_reset();
    val_in = 32'sd42;
    val_in_sync = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      val_in = 32'sd99 + i;
      val_in_sync = i[0];
      tick();
      check_val($sformatf("bp_c_out_%0d", i), 64'(c_out), 64'(mk(READ, 32'sd42, 1'b0)));
      check_val($sformatf("bp_notify_%0d", i), {62'd0, val_in_notify, c_out_notify}, 64'b01);
    end
    val_in_sync = 1'b0;
    c_out_sync = 1'b1;
    tick();
    check_val("bp_tx", 64'(tx_count), 64'd1);
    check_val("bp_idle", {62'd0, val_in_notify, c_out_notify}, 64'b10);
    pass_sample("bp_next", 32'sd11, mk(WRITE, 32'sd11, 1'b0), 16'd2);

    // Most negative value sets the sign flag.
    do_reset();
    pass_sample("minint", 32'sh80000000, mk(READ, -32'sd2147483648, 1'b1), 16'd1);

    // Counter wrap: preload the count while idle, then one transfer.
    do_reset();
    force dut.tx_count_reg = 16'hFFFF;
    tick();
    tick();
    release dut.tx_count_reg;
    tick();
    check_val("preload_tx", 64'(tx_count), 64'hFFFF);
    pass_sample("wrap", 32'sd1, mk(READ, 32'sd1, 1'b0), 16'd0);

    // Async reset in the middle of a pending send.
    do_reset();
    pass_sample("pre_rst", 32'sd8, mk(READ, 32'sd8, 1'b0), 16'd1);
    val_in = 32'sd77;
    val_in_sync = 1'b1;
    c_out_sync = 1'b0;
    tick();
    val_in_sync = 1'b0;
    check_val("send_c_out", 64'(c_out), 64'(mk(WRITE, 32'sd77, 1'b0)));
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_c_out", 64'(c_out), 64'(mk(READ, 32'sd0, 1'b0)));
    check_val("arst_notify", {62'd0, val_in_notify, c_out_notify}, 64'b10);
    check_val("arst_tx", 64'(tx_count), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    pass_sample("post_rst", 32'sd3, mk(READ, 32'sd3, 1'b0), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/testbasic14_source.md
TESTBASIC14_SOURCE -- requirements
Module: testbasic14_source

Interface
REQ-001 The block SHALL import testbasic14_types and use CompoundType {mode: read/write enum, x: 32-bit signed, y: 1-bit} on its output port.
REQ-002 The block SHALL have the following ports, each line giving name, direction, width and meaning:
- clk  input  1  sole clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-low reset; 0 = reset.
- val_in  input  32  signed sample offered by the upstream producer.
- val_in_sync  input  1  upstream has a valid sample on val_in.
- val_in_notify  output  1  block is ready to accept val_in.
- c_out  output  CompoundType  transaction fed to the downstream TestBasic14 b_in port.
- c_out_sync  input  1  downstream ready; connects to the consumer's b_in_notify.
- c_out_notify  output  1  c_out is valid; connects to the consumer's b_in_sync.
- tx_count  output  16  number of completed output transfers, wrapping.
REQ-003 A transfer on a port SHALL occur in a cycle where that port's _sync and _notify are both 1 at posedge clk.

Function
REQ-004 Section register states SHALL be: section_fetch and section_send.
REQ-005 In section_fetch, val_in_notify SHALL be 1 and c_out_notify SHALL be 0.
REQ-006 In section_fetch with val_in_sync=1, the block SHALL, on that edge:
- latch c_out.x = val_in;
- set c_out.y = 1 if val_in is negative (bit 31 set), else 0;
- set c_out.mode = the current mode toggle value;
- set val_in_notify=0 and c_out_notify=1;
- move to section_send.
REQ-007 In section_fetch with val_in_sync=0, all state SHALL hold.
REQ-008 In section_send, c_out SHALL hold its value and stay stable until the transfer completes.
REQ-009 In section_send with c_out_sync=1, the block SHALL, on that edge:
- set c_out_notify=0 and val_in_notify=1;
- toggle the mode (read->write, write->read);
- increment tx_count by 1 modulo 2^16;
- move to section_fetch.
REQ-010 In section_send with c_out_sync=0, all state SHALL hold (backpressure of any length).
REQ-011 Latency SHALL be one cycle: c_out is valid on the edge after the input transfer.
REQ-012 Maximum throughput SHALL be one transaction per two cycles.
REQ-013 The block SHALL never assert val_in_notify and c_out_notify in the same cycle.
REQ-014 tx_count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-015 val_in_sync asserted while in section_send SHALL be ignored; no sample is captured or lost by the block.
REQ-016 The notify outputs and c_out SHALL be registered only; there is no combinational path from any input to any output.

Reset
REQ-017 While rst=0, regardless of clk, the block SHALL hold:
- section = section_fetch;
- c_out.mode = read, c_out.x = 0, c_out.y = 0;
- mode toggle = read;
- val_in_notify = 1, c_out_notify = 0;
- tx_count = 0.
REQ-018 Reset asserted mid-transaction (section_send) SHALL abandon the pending c_out without completing a transfer, and tx_count SHALL clear.
REQ-019 After rst rises, the first accepted sample SHALL produce mode = read.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset then val_in=5 with sync=1 and c_out_sync=1 -> next cycle c_out={read,5,0} with notify=1; one cycle later tx_count=1 and val_in_notify=1.
- Three back-to-back samples 7, -3, 0 with the consumer always ready -> c_out sequence {read,7,0}, {write,-3,1}, {read,0,0}, one transfer every 2 cycles, tx_count=3.
- Hold c_out_sync=0 for 10 cycles after capturing 42 -> c_out stays {read,42,0} with notify=1 throughout; val_in_sync pulses are ignored; transfer occurs on the first c_out_sync=1.
- val_in=32'h80000000 -> c_out.x=-2147483648, y=1.
- Preload 65535 transfers, then one more -> tx_count=0.
- Assert rst=0 asynchronously in section_send -> outputs take reset values immediately; after release, the next sample gives mode=read and tx_count=1.
